// File: rtl/adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// adder_ctrl_pkg
// Shared definitions for the nibble-serial add/subtract sequencer and its
// 4-bit adder slice.
//   NIBBLE_W  : width of the shared adder slice (one nibble per clock)
//   state_e   : sequencer state encoding, shared with the host FSM
//   idxWidth  : width of the nibble index counter for a given nibble count
// ---------------------------------------------------------------------------
package adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  // Encoding is visible to the host FSM, so the values are pinned.
  // 2'd3 is never entered; the sequencer steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-nibble configuration still needs a 1-bit index so that the
  // counter register has a legal width.
  function automatic int idxWidth(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_adder_cin.sv
// ---------------------------------------------------------------------------
// nibble_adder_cin
// Purely combinational 4-bit ripple-carry adder with carry in. This is the
// single datapath slice that the sequencer reuses once per nibble.
//   a, b : nibble operands
//   ci   : carry in
//   s    : nibble sum
//   co   : carry out of bit 3
// ---------------------------------------------------------------------------
module nibble_adder_cin
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  // Classic ripple chain: each bit produces its sum from the incoming carry
  // and generates/propagates the carry for the next bit. The carry is kept
  // in a block-local variable so the chain is evaluated in bit order.
  always_comb begin : rippleChain
    logic rippleCarry;
    rippleCarry = ci;
    s           = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]        = a[i] ^ b[i] ^ rippleCarry;
      rippleCarry = (a[i] & b[i]) | (rippleCarry & (a[i] ^ b[i]));
    end
    co = rippleCarry;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Performs a WIDTH-bit add or subtract by passing the operands through one
// shared 4-bit adder slice, one nibble per clock, least significant nibble
// first. The carry between nibbles lives in a register. A start/busy/done
// handshake lets a host FSM issue wide arithmetic without a full-width adder.
//
// Parameters
//   WIDTH : operand/result width; must be a multiple of 4 and at least 4
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset; aborts a running operation
//   start : request, only looked at in IDLE
//   sub   : 0 = a+b, 1 = a-b, captured with start
//   a, b  : operands, captured with start
//   busy  : high while nibbles are being processed (NIBBLES cycles)
//   done  : one-cycle pulse when sum/cout/ovf are valid
//   sum   : result register, filled nibble by nibble
//   cout  : carry out of the MSB; for subtract, 1 means no borrow
//   ovf   : signed two's-complement overflow
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idxWidth(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] sliceA;
  logic [NIBBLE_W-1:0] sliceB;
  logic [NIBBLE_W-1:0] sliceSum;
  logic                sliceCo;
  logic                lastNibble;

  // Pick the nibble currently being processed out of the captured operands.
  // bReg already holds ~b for a subtract, so the slice only ever adds.
  always_comb begin
    sliceA     = aReg_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    sliceB     = bReg_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    lastNibble = (idx_q == LAST_IDX);
  end

  // The one shared adder slice; carry in comes from the inter-nibble
  // carry register.
  nibble_adder_cin u_slice (
    .a  (sliceA),
    .b  (sliceB),
    .ci (carry_q),
    .s  (sliceSum),
    .co (sliceCo)
  );

  // State register. Reset is synchronous and beats everything else, so a
  // reset during RUN simply drops back to IDLE without ever reaching DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only honoured in IDLE; while RUN or DONE it
  // is ignored and nothing is queued. The unused encoding recovers to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (lastNibble) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. Both handshake outputs are pure decodes of the state, so
  // busy covers exactly the NIBBLES RUN cycles and done the single DONE cycle.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state. On an accepted start the operands are captured and
  // subtraction is turned into a + ~b + 1 by inverting b and seeding the
  // carry with 1. Each RUN cycle writes one result nibble and advances the
  // index; the final nibble also latches cout and the signed overflow, which
  // is the MSB carry-in xor carry-out expressed from the operand MSBs.
  always_comb begin
    aReg_d  = aReg_q;
    bReg_d  = bReg_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aReg_d  = a;
          bReg_d  = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = sliceSum;
        carry_d = sliceCo;
        if (lastNibble) begin
          idx_d  = '0;
          cout_d = sliceCo;
          ovf_d  = aReg_q[WIDTH-1] ^ bReg_q[WIDTH-1] ^ sliceSum[NIBBLE_W-1] ^ sliceCo;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers. Everything clears on reset so a host sees a clean
  // zero result after an aborted operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      aReg_q  <= '0;
      bReg_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      aReg_q  <= aReg_d;
      bReg_q  <= bReg_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result outputs come straight from their registers.
  always_comb begin
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Self-checking bench for the nibble-serial adder sequencer. A 16-bit and a
// 4-bit instance share clock and reset. Expected results come from a
// full-width arithmetic model and travel through a scoreboard queue from the
// cycle a start is accepted to the cycle done is seen.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst;

  logic        start16, sub16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic        start4, sub4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  int   testsRun;
  int   failCount;
  res_t expQ[$];

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .sub   (sub16),
    .a     (a16),
    .b     (b16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16),
    .ovf   (ovf16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .sub   (sub4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic for a w-bit add or subtract: plain integer maths
  // on the whole word, overflow from operand/result sign agreement.
  function automatic res_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic s);
    logic [31:0] mask;
    logic [31:0] bb;
    logic [31:0] full;
    res_t        r;
    mask   = (32'd1 << w) - 32'd1;
    bb     = s ? (~{16'h0000, y}) & mask : {16'h0000, y};
    full   = {16'h0000, x} + bb + {31'd0, s};
    r.sum  = 16'(full & mask);
    r.cout = full[w];
    r.ovf  = (x[w-1] == bb[w-1]) && (r.sum[w-1] != x[w-1]);
    return r;
  endfunction

  // Every comparison goes through here so the counters stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected 16-bit result and compare against the outputs.
  task automatic popAndCompare(input string tag);
    res_t exp;
    checkOutput({tag, "_qdepth"}, 32'(expQ.size() > 0), 32'd1);
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      checkOutput({tag, "_sum"},  32'(sum16),  32'(exp.sum));
      checkOutput({tag, "_cout"}, 32'(cout16), 32'(exp.cout));
      checkOutput({tag, "_ovf"},  32'(ovf16),  32'(exp.ovf));
    end
  endtask

  // One complete 16-bit operation: start for one cycle, then watch busy and
  // done for a bounded number of cycles. done must appear exactly once,
  // NIBBLES+1 falling edges after the start was driven.
  task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                               input logic opSub, input string tag);
    int busyCycles;
    int donePulses;
    int doneAt;
    busyCycles = 0;
    donePulses = 0;
    doneAt     = 0;
    @(negedge clk);
    a16     = opA;
    b16     = opB;
    sub16   = opSub;
    start16 = 1'b1;
    expQ.push_back(model(16, opA, opB, opSub));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start16 = 1'b0;
      if (busy16) busyCycles++;
      if (done16) begin
        donePulses++;
        doneAt = k;
        popAndCompare(tag);
      end
    end
    checkOutput({tag, "_donePulses"}, 32'(donePulses), 32'd1);
    checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'd4);
    checkOutput({tag, "_doneAt"},     32'(doneAt),     32'd5);
  endtask

  // Global safety net in case something unforeseen stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   donePulses;
    int   busyCycles;
    int   doneAt;
    res_t exp4;

    testsRun  = 0;
    failCount = 0;
    rst     = 1'b1;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    start4  = 1'b0; sub4  = 1'b0; a4  = '0; b4  = '0;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy16), 32'd0);
    checkOutput("rst_done", 32'(done16), 32'd0);
    checkOutput("rst_sum",  32'(sum16),  32'd0);
    checkOutput("rst_cout", 32'(cout16), 32'd0);
    checkOutput("rst_ovf",  32'(ovf16),  32'd0);
    checkOutput("rst4_sum", 32'(sum4),   32'd0);
    checkOutput("rst4_busy", 32'(busy4), 32'd0);

    // Basic add plus carry-out and signed-overflow corners, both directions.
    applyStimulus(16'h1234, 16'h0FFF, 1'b0, "add_basic");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    applyStimulus(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    applyStimulus(16'h8000, 16'h0001, 1'b1, "sub_ovf");
    applyStimulus(16'hA5C3, 16'h5A3C, 1'b1, "sub_mixed");

    // Idle outputs keep the last result.
    repeat (3) @(negedge clk);
    checkOutput("hold_sum", 32'(sum16), 32'(model(16, 16'hA5C3, 16'h5A3C, 1'b1).sum));

    // start pulsed mid-RUN with different operands must be ignored.
    donePulses = 0;
    @(negedge clk);
    a16 = 16'h0001; b16 = 16'h0001; sub16 = 1'b0; start16 = 1'b1;
    expQ.push_back(model(16, 16'h0001, 16'h0001, 1'b0));
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done16) begin
        donePulses++;
        popAndCompare("ignore_start");
      end
      if (k == 1) start16 = 1'b0;
      if (k == 2) begin
        a16 = 16'hAAAA; b16 = 16'h0000; start16 = 1'b1;
      end
      if (k == 3) start16 = 1'b0;
    end
    checkOutput("ignore_donePulses", 32'(donePulses), 32'd1);

    // start held high: an operation is accepted every 6 cycles, each with
    // the operands present at its own accept edge.
    @(negedge clk);
    start16 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("cont_done_%0d", k), 32'(done16), 32'((k % 6) == 5));
      if (done16) popAndCompare($sformatf("cont_%0d", k));
      a16   = 16'(k * 16'h0F37 + 16'h8421);
      b16   = 16'(k * 16'h03C5 + 16'h7FFF);
      sub16 = 1'((k / 6) % 2);
      if ((k % 6) == 0) expQ.push_back(model(16, a16, b16, sub16));
    end
    start16 = 1'b0;
    checkOutput("cont_qempty", 32'(expQ.size()), 32'd0);

    // Reset during the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h5678; sub16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy16), 32'd0);
    checkOutput("abort_sum",  32'(sum16),  32'd0);
    checkOutput("abort_cout", 32'(cout16), 32'd0);
    checkOutput("abort_ovf",  32'(ovf16),  32'd0);
    donePulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done16) donePulses++;
    end
    checkOutput("abort_noDone", 32'(donePulses), 32'd0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, "after_abort");

    // Single-nibble instance: busy one cycle, done two edges after start.
    exp4       = model(4, 16'h0009, 16'h0008, 1'b0);
    donePulses = 0;
    busyCycles = 0;
    doneAt     = 0;
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h8; sub4 = 1'b0; start4 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start4 = 1'b0;
      if (busy4) busyCycles++;
      if (done4) begin
        donePulses++;
        doneAt = k;
        checkOutput("w4_sum",  32'(sum4),  32'(exp4.sum[3:0]));
        checkOutput("w4_cout", 32'(cout4), 32'(exp4.cout));
        checkOutput("w4_ovf",  32'(ovf4),  32'(exp4.ovf));
      end
    end
    checkOutput("w4_donePulses", 32'(donePulses), 32'd1);
    checkOutput("w4_busyCycles", 32'(busyCycles), 32'd1);
    checkOutput("w4_doneAt",     32'(doneAt),     32'd2);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-in ripple-adder slice, one nibble per clock, LSB nibble first.
Carry is held in a register between nibbles.
Start/busy/done handshake lets a host FSM issue wide arithmetic without instantiating a full-width adder.
Sits between the control FSM and the shared 4-bit adder datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4, other values unsupported.
NIBBLES, WIDTH/4, derived localparam; number of slice passes.

Ports:
clk    input   1      rising-edge clock; single clock domain.
rst    input   1      synchronous, active-high reset.
start  input   1      request; sampled only in IDLE.
sub    input   1      0 = a+b, 1 = a-b; sampled with start.
a      input   WIDTH  operand A; sampled with start.
b      input   WIDTH  operand B; sampled with start.
busy   output  1      high while in RUN.
done   output  1      one-cycle pulse; sum/cout/ovf valid.
sum    output  WIDTH  result register.
cout   output  1      carry out of MSB; for sub, 1 = no borrow.
ovf    output  1      signed two's-complement overflow.

Behaviour:
- Clock and reset are fixed: one clock (clk); rst synchronous, active-high.
- Reset (rst=1 at a clk edge): state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, busy=0, done=0.
- Reset wins over every other input, including mid-RUN. A mid-RUN reset aborts the operation with no done pulse.
- States (shared encoding): IDLE=0, RUN=1, DONE=2; value 3 is unreachable and recovers to IDLE.
- IDLE, start=1 at an edge:
  - a_reg <= a; b_reg <= sub ? ~b : b; carry <= sub; idx <= 0; state <= RUN.
  - start=0: remain in IDLE; all outputs hold.
- RUN, each edge:
  - {c4,s4} = a_reg[idx] + b_reg[idx] + carry (nibble slices).
  - sum[4*idx+:4] <= s4; carry <= c4; idx <= idx+1.
  - When idx==NIBBLES-1: cout <= c4; ovf <= a_reg[MSB] ^ b_reg[MSB] ^ s4[3] ^ c4; state <= DONE.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- busy=1 in RUN only, so busy is high for exactly NIBBLES cycles.
- start while in RUN or DONE is ignored; no queueing.
- Timing: start sampled at edge E0; nibble i is written at edge E(i+1); done is high in the cycle after E(NIBBLES).
  - Earliest next start is sampled at E(NIBBLES+2), so throughput is one operation per NIBBLES+2 cycles.
- Output validity:
  - sum is updated nibble-by-nibble during RUN and is valid only when done=1, or in IDLE after a completed operation.
  - cout/ovf change only at the final RUN edge.
  - All outputs hold until the next accepted start or reset.
- Arithmetic: modulo 2^WIDTH; no saturation. Subtract uses ~b with initial carry 1.
- idx width is max(1, clog2(NIBBLES)); idx never exceeds NIBBLES-1.

Decomposition:
- Shared package/include adder_ctrl_pkg: state encodings (IDLE/RUN/DONE), NIBBLE_W=4.
- One sub-module, nibble_adder_cin: purely combinational 4-bit ripple adder; ports a[3:0], b[3:0], ci, s[3:0], co. This is the shared datapath slice.
- FSM, operand registers, index counter and carry register stay in the top module.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h0FFF, sub=0, start for 1 cycle -> busy high exactly 4 cycles; done pulses once in the cycle after the 4th RUN edge; sum=16'h2233, cout=0, ovf=0.
- a=16'hFFFF, b=16'h0001, sub=0 -> sum=16'h0000, cout=1, ovf=0; a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
- sub=1: a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0, ovf=0; a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
- Operation a=16'h0001, b=16'h0001 in flight; start pulsed during RUN with a=16'hAAAA -> ignored; result sum=16'h0002. With start held high continuously, done pulses every 6 cycles and each result matches its sampled operands.
- rst asserted during the 2nd RUN cycle -> at the next edge busy=0, sum=0, cout=0, ovf=0, and no done pulse ever appears. A following operation 16'h00FF+16'h0001 gives sum=16'h0100.
- WIDTH=4 (NIBBLES=1), a=4'h9, b=4'h8 -> busy 1 cycle; sum=4'h1, cout=1, ovf=1; done in the 3rd cycle counting the start cycle.
